// File: rtl/scorehand_seq.sv
// scorehand_seq: sequential Baccarat hand scorer.
// Takes one card per cycle over a valid/ready handshake and keeps a registered
// modulo-10 total, the card count, a hand-full flag and the two-card "natural" flag.
// Optional feature: define SCOREHAND_ERR_EN to add the sticky overflow output,
// which flags a card offered while the hand is already full.
module scorehand_seq #(
    parameter int CARD_W    = 4,
    parameter int MAX_CARDS = 3,
    parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              card_valid,
    input  logic [CARD_W-1:0] card_in,
    output logic              card_ready,
    output logic [3:0]        total,
    output logic [CNT_W-1:0]  card_count,
    output logic              hand_full,
`ifdef SCOREHAND_ERR_EN
    output logic              natural,
    output logic              overflow
`else
    output logic              natural
`endif
);

    typedef enum logic [1:0] {EMPTY, ACCUM, FULL} state_t;

    state_t     state;
    logic       accept;
    logic [3:0] total_nxt;

    // Ranks 1..9 score face value; everything else (0, ten, court codes) scores 0.
    function automatic logic [3:0] card_value(input logic [CARD_W-1:0] c);
        if ((int'(c) >= 1) && (int'(c) <= 9)) begin
            return 4'(c);
        end
        return 4'd0;
    endfunction

    // Modulo-10 add of two digits; the 5-bit sum never exceeds 18, so one
    // conditional subtract is enough.
    function automatic logic [3:0] add_mod10(input logic [3:0] t, input logic [3:0] v);
        logic [4:0] s;
        s = {1'b0, t} + {1'b0, v};
        return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
    endfunction

    // Ready depends on state only, so the dealer never sees a valid->ready loop.
    assign card_ready = (state != FULL);
    assign accept     = card_valid && card_ready;
    assign total_nxt  = add_mod10(total, card_value(card_in));
    assign hand_full  = (card_count == CNT_W'(MAX_CARDS));

    // Hand FSM with registered score, count and natural flag; clear acts like reset.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state      <= EMPTY;
            total      <= 4'd0;
            card_count <= '0;
            natural    <= 1'b0;
        end else if (accept) begin
            total      <= total_nxt;
            card_count <= card_count + CNT_W'(1);
            // Natural is decided only by the second card and then frozen.
            if (card_count == CNT_W'(1)) begin
                natural <= (total_nxt >= 4'd8);
            end
            if ((card_count + CNT_W'(1)) == CNT_W'(MAX_CARDS)) begin
                state <= FULL;
            end else begin
                state <= ACCUM;
            end
        end
    end

`ifdef SCOREHAND_ERR_EN
    // Sticky flag for a card offered while the hand is full; only clear/reset drop it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            overflow <= 1'b0;
        end else if (card_valid && (state == FULL)) begin
            overflow <= 1'b1;
        end
    end
`endif

endmodule
